// File: rtl/router_input_fifo.sv
// Per-port router input buffer: first-word-fall-through flit FIFO with
// full/almost-full back-pressure, occupancy count and a sticky drop flag.
module router_input_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       full,
    output logic                       almost_full,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       valid,
    output logic                       empty,
    input  logic                       en,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(DEPTH - AFULL_MARGIN);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_drop_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_nxt;

    // Flags decode the registered count only, so no input reaches them combinationally.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = en & ~w_empty;

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter and sticky overflow indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= {CNT_W{1'b0}};
            r_drop_err <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (in_valid && w_full) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign full        = w_full;
    assign empty       = w_empty;
    assign valid       = ~w_empty;
    assign almost_full = (r_count >= AFULL_C);
    assign out_data    = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign drop_err    = r_drop_err;

endmodule

// File: tb/tb_router_input_fifo.sv
// Self-checking bench for router_input_fifo (DEPTH=4, DATA_WIDTH=8, AFULL_MARGIN=1):
// vector table plus directed corner sequences, with a queue scoreboard for popped flits.
module tb_router_input_fifo;

    localparam int DW = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          full;
    logic          almost_full;
    logic [DW-1:0] out_data;
    logic          valid;
    logic          empty;
    logic          en;
    logic [2:0]    count;
    logic          drop_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_q[$];
    int            m_count;
    logic          m_drop;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          en;
        int            cnt;
        logic          full;
        logic          af;
        logic          emp;
        logic          drop;
    } vec_t;

    vec_t tbl[10];

    router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AFULL_MARGIN(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .full(full), .almost_full(almost_full), .out_data(out_data),
        .valid(valid), .empty(empty), .en(en), .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_drop  = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle: model predicts, popped flit is scored, state checked after the edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic e);
        logic do_push;
        logic do_pop;
        logic [DW-1:0] exp_flit;
        do_push  = iv && (m_count != DEP);
        do_pop   = e && (m_count != 0);
        in_valid = iv;
        in_data  = d;
        en       = e;
        if (do_pop) begin
            exp_flit = sb_q.pop_front();
            chk("pop_data", out_data, exp_flit);
        end
        if (do_push) sb_q.push_back(d);
        if (iv && (m_count == DEP)) m_drop = 1'b1;
        m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        @(posedge clk);
        #1;
        chk("count", count, m_count);
        chk("full", full, (m_count == DEP) ? 1 : 0);
        chk("almost_full", almost_full, (m_count >= DEP - 1) ? 1 : 0);
        chk("empty", empty, (m_count == 0) ? 1 : 0);
        chk("valid", valid, (m_count != 0) ? 1 : 0);
        chk("drop_err", drop_err, m_drop);
        if (m_count != 0) chk("head", out_data, sb_q[0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_out"}, out_data, 0);
        chk({tag, "_drop"}, drop_err, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_af"}, almost_full, 0);
    endtask

    // Async pulse placed mid-cycle; outputs checked before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; en = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two flits stored, then reset mid-cycle must discard them.
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        async_reset("rst_mid");
        cycle(1'b0, 8'h00, 1'b1);

        // Fill to full, overflow drop, then drain.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].iv, tbl[i].d, tbl[i].en);
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_full", full, tbl[i].full);
            chk("tbl_af", almost_full, tbl[i].af);
            chk("tbl_empty", empty, tbl[i].emp);
            chk("tbl_drop", drop_err, tbl[i].drop);
            if (i < 4) chk("tbl_head", out_data, 8'h11);
        end

        // Pointer wrap: one stored flit, then push+pop every cycle.
        async_reset("rst_wrap");
        cycle(1'b1, 8'h01, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            cycle(1'b1, DW'(i), 1'b1);
            chk("wrap_count", count, 1);
            chk("wrap_drop", drop_err, 0);
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_drained", empty, 1);

        // Empty side: en held high, push arrives and pops next edge.
        cycle(1'b1, 8'hA5, 1'b1);
        chk("es_valid", valid, 1);
        chk("es_out", out_data, 8'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        chk("es_empty", empty, 1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("es_count", count, 0);

        // Full side: pop accepted, simultaneous push dropped, retried next cycle.
        cycle(1'b1, 8'h61, 1'b0);
        cycle(1'b1, 8'h62, 1'b0);
        cycle(1'b1, 8'h63, 1'b0);
        cycle(1'b1, 8'h64, 1'b0);
        chk("fs_full", full, 1);
        cycle(1'b1, 8'h66, 1'b1);
        chk("fs_count", count, 3);
        chk("fs_drop", drop_err, 1);
        cycle(1'b1, 8'h66, 1'b0);
        chk("fs_retry_count", count, 4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("fs_empty", empty, 1);
        chk("sb_left", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_input_fifo.md
# router_input_fifo

Per-port input buffer for the mesh router: it sits between an incoming link and the router's flow-control/switch stage. It stores flits written by the upstream sender and presents the head flit first-word-fall-through with `valid`/`empty`. It pops on the flow-control `en` strobe. It generates the `full` back-pressure that upstream flow control consumes. One instance is used per input port: x, y and local.

## Interface
Parameters:
- `DATA_WIDTH`, 32: flit width in bits.
- `DEPTH`, 4: number of entries; must be a power of two and ≥ 2.
- `AFULL_MARGIN`, 1: `almost_full` asserts when occupancy ≥ DEPTH − AFULL_MARGIN; legal range 0..DEPTH−1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input DATA_WIDTH: flit from the upstream link.
- `in_valid` input 1: upstream write request.
- `full` output 1: occupancy == DEPTH; back-pressure to upstream.
- `almost_full` output 1: occupancy ≥ DEPTH − AFULL_MARGIN.
- `out_data` output DATA_WIDTH: head flit, i.e. entry at the read pointer.
- `valid` output 1: head flit present; equals !empty.
- `empty` output 1: occupancy == 0.
- `en` input 1: pop strobe from flow control. It is driven high both when the head flit is forwarded and when no flit is valid.
- `count` output clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `drop_err` output 1: sticky; set when a write is rejected.

## Operation
- Storage: DEPTH×DATA_WIDTH register array, `wr_ptr`/`rd_ptr` of clog2(DEPTH) bits, occupancy counter `count`.
- Write accept condition: push = `in_valid` && !`full`. `full` is evaluated from the registered count, so a simultaneous pop does not make room for a push in the same cycle.
- On push: `mem[wr_ptr]` ← `in_data`; `wr_ptr` increments modulo DEPTH, wrapping from DEPTH−1 to 0.
- Pop condition: pop = `en` && !`empty`. When empty, `en`=1 is a don't-care and is ignored.
- On pop: `rd_ptr` increments modulo DEPTH; the array entry is not cleared.
- `count` next-state rules:
  - push only: +1.
  - pop only: −1.
  - push and pop: unchanged.
  - neither: unchanged.
  - `count` never exceeds DEPTH and never underflows below 0.
- Flags:
  - `full`, `empty`, `almost_full` and `valid` are combinational decodes of the registered `count` only. They have no combinational path from `in_valid` or `en`.
  - `out_data` = `mem[rd_ptr]`, combinational read.
- Error: `in_valid` while `full` drops the flit, leaves state unchanged and sets `drop_err`. `drop_err` clears only on `rst`.
- Reset (async, immediate on `rst` high):
  - pointers = 0, `count` = 0, all array entries = 0, `drop_err` = 0.
  - Resulting outputs: `empty`=1, `valid`=0, `full`=0, `almost_full`=(AFULL_MARGIN==DEPTH? n/a → 0 for legal params), `out_data`=0.
  - Reset mid-operation discards all stored flits.

## Timing
- Write-to-read latency is 1 cycle. A flit pushed at edge k makes `valid`=1 and `out_data` equal to that flit immediately after edge k.
- Pop takes effect at the edge where `en`&&`valid`. The next flit, or `valid`=0, is presented after that edge.
- Sustained throughput is 1 flit/cycle with simultaneous push and pop at any occupancy 1..DEPTH−1.
- At occupancy DEPTH, throughput is limited: the first cycle performs the pop only; pushes resume the following cycle.
- At occupancy 0, a simultaneous push and `en` results in push only; the flit appears the next cycle.
- `full` falls in the cycle after the first pop from DEPTH. It rises in the cycle after the push that reaches DEPTH.

## Test plan
- **Reset values.** Assert `rst` asynchronously mid-cycle with DEPTH=4, DATA_WIDTH=8, 2 flits stored. Required: outputs go to `empty`=1, `valid`=0, `count`=0, `out_data`=0x00, `drop_err`=0 without waiting for a clock edge.
- **Fill to full.** Push 0x11, 0x22, 0x33, 0x44 with `en`=0. Required:
  - `count` steps 1→4.
  - `almost_full`=1 at count 3 (AFULL_MARGIN=1).
  - `full`=1 after the 4th edge.
  - `out_data`=0x11 throughout.
- **Overflow drop.** With the FIFO full, drive `in_valid`=1 with 0x55 for one cycle. Required: `count` stays 4, `drop_err`=1 and stays sticky. Popping then yields only 0x11, 0x22, 0x33, 0x44, then `empty`=1.
- **Pointer wrap-around.** Stream 10 flits 0x01..0x0A with push and pop every cycle, starting from 1 stored flit. Required: output order is preserved, `count` is constant at 1, no `drop_err`, and the pointers wrap past entry 3 twice.
- **Empty-side simultaneity.** With the FIFO empty, hold `en`=1 continuously. Push 0xA5 at edge k. Required: `valid`=1 and `out_data`=0xA5 after edge k; the flit is popped at edge k+1; `empty`=1 after k+1; `count` never goes negative.
- **Full-side simultaneity.** With the FIFO full, drive `en`=1 and `in_valid`=1 with 0x66 at the same edge. Required: the pop is accepted, the push is rejected and `drop_err` is set, `count`=3. The next cycle's push of 0x66 is accepted.
